// File: rtl/mos_seq_sched_pkg.sv
// ---------------------------------------------------------------------------
// mos_seq_sched_pkg
// Shared types and constants for the sequential MOS ranking scheduler.
//   mos_par_t : 3-bit transistor operand (W, V_GS, V_DS)
//   metric_t  : 7-bit Id or gm value produced by mos_eval
//   sum_t     : 10-bit weighted result
//   state_e   : scheduler FSM states
// Optional build macro used by the scheduler: MOS_PROTO_CHK_EN
// ---------------------------------------------------------------------------
package mos_seq_sched_pkg;

  typedef logic [2:0] mos_par_t;
  typedef logic [6:0] metric_t;
  typedef logic [9:0] sum_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SUM,
    OUT
  } state_e;

  // Transistors per transaction; the 3+3 split of the ranked array assumes 6.
  localparam int N_MOS = 6;

  localparam mos_par_t   VTH   = 3'd1;
  localparam logic [9:0] K_DIV = 10'd3;

  localparam sum_t ID_W0 = 10'd3;
  localparam sum_t ID_W1 = 10'd4;
  localparam sum_t ID_W2 = 10'd5;
  localparam sum_t GM_W0 = 10'd1;
  localparam sum_t GM_W1 = 10'd1;
  localparam sum_t GM_W2 = 10'd1;

  // Weighted sum of three ranked metrics; worst case 3*84+4*84+5*84 = 1008 fits in 10 bits.
  function automatic sum_t weighted3(input metric_t a, input metric_t b, input metric_t c,
                                     input sum_t w0, input sum_t w1, input sum_t w2);
    return (w0 * sum_t'(a)) + (w1 * sum_t'(b)) + (w2 * sum_t'(c));
  endfunction

endpackage

// File: rtl/mos_seq_sched_if.sv
// ---------------------------------------------------------------------------
// mos_seq_sched_if
// Groups the sample handshake and result signals of the scheduler.
//   in_valid, W, V_GS, V_DS, mode : driven by the master (sample source)
//   out_valid, out_n               : driven by the slave (scheduler)
//   proto_err                      : slave output, present only with MOS_PROTO_CHK_EN
// Modports: master (sample source / bench), slave (mos_seq_sched).
// ---------------------------------------------------------------------------
interface mos_seq_sched_if;
  import mos_seq_sched_pkg::*;

  logic     in_valid;
  mos_par_t W;
  mos_par_t V_GS;
  mos_par_t V_DS;
  logic [1:0] mode;
  logic     out_valid;
  sum_t     out_n;
`ifdef MOS_PROTO_CHK_EN
  logic     proto_err;
`endif

  modport master (
    output in_valid, W, V_GS, V_DS, mode,
    input  out_valid, out_n
`ifdef MOS_PROTO_CHK_EN
    , input proto_err
`endif
  );

  modport slave (
    input  in_valid, W, V_GS, V_DS, mode,
    output out_valid, out_n
`ifdef MOS_PROTO_CHK_EN
    , output proto_err
`endif
  );

endinterface

// File: rtl/mos_seq_sched_eval.sv
// ---------------------------------------------------------------------------
// mos_eval
// Combinational Id and gm for one transistor with the long-channel model:
//   vov = V_GS - VTH
//   triode     (vov > V_DS): id = W*(2*vov*V_DS - V_DS^2)/K_DIV, gm = 2*W*V_DS/K_DIV
//   saturation (otherwise) : id = W*vov^2/K_DIV,               gm = 2*W*vov/K_DIV
// All arithmetic is unsigned with floor division.
// Ports:
//   w_i, vgs_i, vds_i : transistor operands (3 bits each)
//   id_o, gm_o        : 7-bit results
// ---------------------------------------------------------------------------
module mos_eval
  import mos_seq_sched_pkg::*;
(
  input  mos_par_t w_i,
  input  mos_par_t vgs_i,
  input  mos_par_t vds_i,
  output metric_t  id_o,
  output metric_t  gm_o
);

  mos_par_t   vov;
  logic [9:0] w10;
  logic [9:0] vov10;
  logic [9:0] vds10;
  logic [9:0] idNum;
  logic [9:0] gmNum;

  assign vov   = vgs_i - VTH;
  assign w10   = 10'(w_i);
  assign vov10 = 10'(vov);
  assign vds10 = 10'(vds_i);

  // Region select and numerators; 10 bits hold the largest product (7*84 = 588),
  // and in triode 2*vov*V_DS always exceeds V_DS^2 so the subtraction never wraps.
  always_comb begin
    if (vov > vds_i) begin
      idNum = w10 * ((10'd2 * vov10 * vds10) - (vds10 * vds10));
      gmNum = 10'd2 * w10 * vds10;
    end else begin
      idNum = w10 * vov10 * vov10;
      gmNum = 10'd2 * w10 * vov10;
    end
  end

  assign id_o = metric_t'(idNum / K_DIV);
  assign gm_o = metric_t'(gmNum / K_DIV);

endmodule

// File: rtl/mos_seq_sched.sv
// ---------------------------------------------------------------------------
// mos_seq_sched
// Sequential Id/gm ranking scheduler. Takes one transistor per valid cycle,
// evaluates it on a single shared mos_eval, insertion-sorts the selected
// metric into a descending 6-entry array, then emits the mode-weighted sum of
// the top or bottom three as a one-cycle registered strobe.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mos_seq_sched_if.slave (in_valid, W, V_GS, V_DS, mode in;
//           out_valid, out_n out; proto_err out when MOS_PROTO_CHK_EN)
// Build option: define MOS_PROTO_CHK_EN to add the proto_err pulse, raised for
// in_valid during SUM/OUT or a zero operand on a sampled cycle.
// ---------------------------------------------------------------------------
module mos_seq_sched
  import mos_seq_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  mos_seq_sched_if.slave  bus
);

  state_e     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [1:0] mode_q, mode_d;
  metric_t    rank_q [N_MOS];
  metric_t    rank_d [N_MOS];
  sum_t       sum_q, sum_d;
  logic       out_valid_q, out_valid_d;
  sum_t       out_n_q, out_n_d;
`ifdef MOS_PROTO_CHK_EN
  logic       proto_err_q, proto_err_d;
`endif

  metric_t          idVal;
  metric_t          gmVal;
  metric_t          metricSel;
  logic             useId;
  logic             sampling;
  logic [N_MOS-1:0] lt;
  metric_t          rankIns [N_MOS];
  sum_t             sumVal;

  mos_eval u_eval (
    .w_i   (bus.W),
    .vgs_i (bus.V_GS),
    .vds_i (bus.V_DS),
    .id_o  (idVal),
    .gm_o  (gmVal)
  );

  // The first sample arrives before mode is latched, so in IDLE the metric is
  // chosen from the live mode input; afterwards only the latched mode counts.
  always_comb begin
    useId     = (state_q == IDLE) ? bus.mode[0] : mode_q[0];
    metricSel = useId ? idVal : gmVal;
    sampling  = bus.in_valid && ((state_q == IDLE) || (state_q == LOAD));
  end

  // Insertion into the descending array. lt is monotone (0s then 1s), so the
  // new value lands at the first strictly-smaller slot and everything below
  // shifts down by one, dropping the last entry.
  always_comb begin
    for (int i = 0; i < N_MOS; i++) begin
      lt[i] = rank_q[i] < metricSel;
    end
    rankIns[0] = lt[0] ? metricSel : rank_q[0];
    for (int i = 1; i < N_MOS; i++) begin
      if (!lt[i]) begin
        rankIns[i] = rank_q[i];
      end else if (lt[i-1]) begin
        rankIns[i] = rank_q[i-1];
      end else begin
        rankIns[i] = metricSel;
      end
    end
  end

  // Weighted adder over either the top three or bottom three ranks.
  always_comb begin
    if (mode_q[1]) begin
      if (mode_q[0]) sumVal = weighted3(rank_q[0], rank_q[1], rank_q[2], ID_W0, ID_W1, ID_W2);
      else           sumVal = weighted3(rank_q[0], rank_q[1], rank_q[2], GM_W0, GM_W1, GM_W2);
    end else begin
      if (mode_q[0]) sumVal = weighted3(rank_q[3], rank_q[4], rank_q[5], ID_W0, ID_W1, ID_W2);
      else           sumVal = weighted3(rank_q[3], rank_q[4], rank_q[5], GM_W0, GM_W1, GM_W2);
    end
  end

  // Next-state logic. The output strobe is loaded on the OUT->IDLE edge so it
  // appears two edges after the sixth sample; the rank array is cleared on
  // the same edge so nothing carries into the next transaction.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mode_d      = mode_q;
    sum_d       = sum_q;
    out_valid_d = 1'b0;
    out_n_d     = '0;
    for (int i = 0; i < N_MOS; i++) begin
      rank_d[i] = rank_q[i];
    end

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mode_d  = bus.mode;
          count_d = 3'd1;
          state_d = LOAD;
          for (int i = 0; i < N_MOS; i++) rank_d[i] = rankIns[i];
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          for (int i = 0; i < N_MOS; i++) rank_d[i] = rankIns[i];
          if (count_q == 3'(N_MOS - 1)) begin
            count_d = 3'd0;
            state_d = SUM;
          end else begin
            count_d = count_q + 3'd1;
          end
        end
      end
      SUM: begin
        sum_d   = sumVal;
        state_d = OUT;
      end
      OUT: begin
        out_valid_d = 1'b1;
        out_n_d     = sum_q;
        state_d     = IDLE;
        for (int i = 0; i < N_MOS; i++) rank_d[i] = '0;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MOS_PROTO_CHK_EN
  // Protocol flag: stray in_valid while busy, or a zero operand on a sample.
  always_comb begin
    proto_err_d = 1'b0;
    if (bus.in_valid && ((state_q == SUM) || (state_q == OUT))) proto_err_d = 1'b1;
    if (sampling && ((bus.W == '0) || (bus.V_GS == '0) || (bus.V_DS == '0))) proto_err_d = 1'b1;
  end
`endif

  // State and datapath registers, all cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mode_q      <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
      for (int i = 0; i < N_MOS; i++) rank_q[i] <= '0;
`ifdef MOS_PROTO_CHK_EN
      proto_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_n_q     <= out_n_d;
      for (int i = 0; i < N_MOS; i++) rank_q[i] <= rank_d[i];
`ifdef MOS_PROTO_CHK_EN
      proto_err_q <= proto_err_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_n     = out_n_q;
`ifdef MOS_PROTO_CHK_EN
  assign bus.proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_mos_seq_sched.sv
// ---------------------------------------------------------------------------
// tb_mos_seq_sched
// Scoreboard bench for mos_seq_sched. The driver pushes the hand-computed
// result and the cycle it is due when it issues the sixth sample; a monitor
// pops and compares whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_mos_seq_sched;
  import mos_seq_sched_pkg::*;

  typedef struct {
    int sum;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   testsRun = 0;
  int   testsFailed = 0;
  exp_t expQ[$];
  exp_t monE;
  bit   protoSeen = 1'b0;

  mos_seq_sched_if bus();

  mos_seq_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock and edge counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared comparison helper: counts every check, reports only failures.
  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: on the falling edge, pop the scoreboard for each result strobe
  // and confirm out_n stays zero between strobes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out_valid", 1, 0);
        end else begin
          monE = expQ.pop_front();
          checkOutput("out_n", int'(bus.out_n), monE.sum);
          checkOutput("latency", cyc, monE.due);
        end
      end else begin
        checkOutput("out_n_idle_zero", int'(bus.out_n), 0);
      end
    end
`ifdef MOS_PROTO_CHK_EN
    if (bus.proto_err === 1'b1) protoSeen = 1'b1;
`endif
  end

  // Asynchronous reset pulse; outputs must clear without waiting for a clock.
  task automatic doReset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", int'(bus.out_valid), 0);
    checkOutput("reset_out_n", int'(bus.out_n), 0);
`ifdef MOS_PROTO_CHK_EN
    checkOutput("reset_proto_err", int'(bus.proto_err), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one transaction starting at a falling edge in IDLE. Later samples
  // carry an inverted mode that must be ignored. gap3 idles before the 4th
  // sample, holdAfter keeps in_valid high through SUM/OUT, abortAt resets
  // after sample abortAt (6 = during OUT). Returns on the edge the result
  // is due, so the next call starts in IDLE.
  task automatic applyStimulus(input logic [5:0][2:0] wv, input logic [5:0][2:0] vgsv,
                               input logic [5:0][2:0] vdsv, input logic [1:0] md,
                               input int gap3, input bit holdAfter, input int abortAt,
                               input int expN);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        repeat (gap3) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b1;
      bus.W    = wv[i];
      bus.V_GS = vgsv[i];
      bus.V_DS = vdsv[i];
      bus.mode = (i == 0) ? md : ~md;
      if (i == 5 && abortAt < 0) begin
        e.sum = expN;
        e.due = cyc + 3;
        expQ.push_back(e);
      end
      @(negedge clk);
      if (abortAt == i) begin
        doReset();
        return;
      end
    end
    bus.in_valid = holdAfter;
    bus.W    = 3'd1;
    bus.V_GS = 3'd2;
    bus.V_DS = 3'd1;
    bus.mode = ~md;
    @(negedge clk);
    if (abortAt == 6) begin
      doReset();
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.W        = 3'd0;
    bus.V_GS     = 3'd0;
    bus.V_DS     = 3'd0;
    bus.mode     = 2'b00;
    repeat (2) @(negedge clk);
    checkOutput("por_out_valid", int'(bus.out_valid), 0);
    checkOutput("por_out_n", int'(bus.out_n), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Saturation at max operands: Id 84 x6 top -> 1008; gm 28 x6 bottom -> 84.
    applyStimulus({6{3'd7}}, {6{3'd7}}, {6{3'd7}}, 2'b11, 0, 1'b0, -1, 1008);
    applyStimulus({6{3'd7}}, {6{3'd7}}, {6{3'd7}}, 2'b00, 0, 1'b0, -1, 84);

    // Ascending then descending W: Id 12..72 -> bottom 264, top 696.
    applyStimulus({3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, {6{3'd7}}, {6{3'd7}}, 2'b01, 0, 1'b0, -1, 264);
    applyStimulus({3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, {6{3'd7}}, {6{3'd7}}, 2'b11, 0, 1'b0, -1, 696);
    applyStimulus({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, {6{3'd7}}, {6{3'd7}}, 2'b01, 0, 1'b0, -1, 264);
    applyStimulus({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, {6{3'd7}}, {6{3'd7}}, 2'b11, 0, 1'b0, -1, 696);

    // gm = 4*W (4..24): top three 24+20+16 = 60, bottom three 4+8+12 = 24.
    applyStimulus({3'd2, 3'd5, 3'd1, 3'd6, 3'd3, 3'd4}, {6{3'd7}}, {6{3'd7}}, 2'b10, 0, 1'b0, -1, 60);
    applyStimulus({3'd2, 3'd5, 3'd1, 3'd6, 3'd3, 3'd4}, {6{3'd7}}, {6{3'd7}}, 2'b00, 0, 1'b0, -1, 24);

    // Triode: W=3, V_GS=5, V_DS=1 -> id 7 each -> 84, with and without a stall.
    applyStimulus({6{3'd3}}, {6{3'd5}}, {6{3'd1}}, 2'b11, 0, 1'b0, -1, 84);
    applyStimulus({6{3'd3}}, {6{3'd5}}, {6{3'd1}}, 2'b11, 2, 1'b0, -1, 84);

    // Reset after the 4th sample, then a fresh max transaction.
    applyStimulus({6{3'd7}}, {6{3'd7}}, {6{3'd7}}, 2'b11, 0, 1'b0, 3, 0);
    applyStimulus({6{3'd7}}, {6{3'd7}}, {6{3'd7}}, 2'b11, 0, 1'b0, -1, 1008);

    // Reset during OUT: the transaction must never strobe.
    applyStimulus({6{3'd7}}, {6{3'd7}}, {6{3'd7}}, 2'b11, 0, 1'b0, 6, 0);

    // Reset while the result strobe is high must clear it at once.
    applyStimulus({6{3'd7}}, {6{3'd7}}, {6{3'd7}}, 2'b00, 0, 1'b0, -1, 84);
    #2;
    doReset();

    // in_valid held through SUM/OUT, then a back-to-back transaction.
    protoSeen = 1'b0;
    applyStimulus({6{3'd7}}, {6{3'd7}}, {6{3'd7}}, 2'b11, 0, 1'b1, -1, 1008);
`ifdef MOS_PROTO_CHK_EN
    checkOutput("proto_err_busy_valid", int'(protoSeen), 1);
`endif
    protoSeen = 1'b0;
    applyStimulus({3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, {6{3'd7}}, {6{3'd7}}, 2'b11, 0, 1'b0, -1, 696);
`ifdef MOS_PROTO_CHK_EN
    checkOutput("proto_err_quiet", int'(protoSeen), 0);
`endif

    // A zero W still computes (id 0), leaving five 84s -> top three 1008.
    protoSeen = 1'b0;
    applyStimulus({3'd7, 3'd7, 3'd7, 3'd0, 3'd7, 3'd7}, {6{3'd7}}, {6{3'd7}}, 2'b11, 0, 1'b0, -1, 1008);
`ifdef MOS_PROTO_CHK_EN
    checkOutput("proto_err_zero_w", int'(protoSeen), 1);
`endif

    for (int k = 0; k < 10 && expQ.size() != 0; k++) @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
